// File: rtl/sirv_gnrl_pkg.sv
// Shared helpers for the sirv_gnrl register FIFO family: width functions and depth limits.
package sirv_gnrl_pkg;

  localparam int unsigned FIFO_DP_MAX = 16;

  function automatic int unsigned sirv_clog2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Pointer width, kept at least one bit so a single-entry FIFO still has a pointer.
  function automatic int unsigned sirv_ptr_w(input int unsigned dp);
    return (dp > 1) ? sirv_clog2(dp) : 1;
  endfunction

endpackage

// File: rtl/sirv_gnrl_fifo_ptr.sv
// Wrap-around FIFO pointer: counts 0..DP-1 on inc_i, async reset to 0.
module sirv_gnrl_fifo_ptr
  import sirv_gnrl_pkg::*;
#(
  parameter int DP = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      inc_i,
  output logic [sirv_ptr_w(DP)-1:0] ptr_o
);

  localparam int PW = sirv_ptr_w(DP);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) begin
      ptr_d = (ptr_q == PW'(DP - 1)) ? '0 : ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/sirv_gnrl_regfifo.sv
// Flop-based valid/ready FIFO of DP entries x DW bits.
// Optional same-cycle pass-through when empty: define SIRV_GNRL_REGFIFO_BYPASS_EN.
module sirv_gnrl_regfifo
  import sirv_gnrl_pkg::*;
#(
  parameter int DW = 32,
  parameter int DP = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_vld,
  output logic                          i_rdy,
  input  logic [DW-1:0]                 i_dat,
  output logic                          o_vld,
  input  logic                          o_rdy,
  output logic [DW-1:0]                 o_dat,
  output logic [sirv_clog2(DP+1)-1:0]   count
);

  localparam int CW = sirv_clog2(DP + 1);
  localparam int PW = sirv_ptr_w(DP);

  if (DW < 1) begin : g_dw_chk
    $error("sirv_gnrl_regfifo: DW must be >= 1");
  end
  if (DP < 1) begin : g_dp_chk
    $error("sirv_gnrl_regfifo: DP must be >= 1");
  end
  if (DP > FIFO_DP_MAX) begin : g_dp_max_chk
    $warning("sirv_gnrl_regfifo: DP exceeds the intended flop-FIFO depth");
  end

  logic [DW-1:0] mem_q [DP];
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          push;
  logic          pop;
  logic          empty;
  logic          bypass;

  assign empty = (count_q == '0);
  assign i_rdy = (count_q != CW'(DP));

`ifdef SIRV_GNRL_REGFIFO_BYPASS_EN
  assign bypass = empty && i_vld;
`else
  assign bypass = 1'b0;
`endif

  assign o_vld = !empty || bypass;
  assign o_dat = bypass ? i_dat : mem_q[rptr];

  // A pass-through beat consumed downstream is neither written nor popped.
  assign push = i_vld && i_rdy && !(bypass && o_rdy);
  assign pop  = !empty && o_rdy;

  sirv_gnrl_fifo_ptr #(.DP(DP)) u_wptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (push),
    .ptr_o (wptr)
  );

  sirv_gnrl_fifo_ptr #(.DP(DP)) u_rptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (pop),
    .ptr_o (rptr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < DP; k++) begin
        mem_q[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < DP; k++) begin
        if (push && (wptr == PW'(k))) begin
          mem_q[k] <= i_dat;
        end
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_sirv_gnrl_regfifo.sv
// Scoreboard bench for sirv_gnrl_regfifo (DP=4, DW=8); honours SIRV_GNRL_REGFIFO_BYPASS_EN.
module tb_sirv_gnrl_regfifo;

  localparam int DW = 8;
  localparam int DP = 4;

  logic          clk;
  logic          rst_n;
  logic          i_vld;
  logic          i_rdy;
  logic [DW-1:0] i_dat;
  logic          o_vld;
  logic          o_rdy;
  logic [DW-1:0] o_dat;
  logic [2:0]    count;

  int            total;
  int            bad;
  int            mcount;
  bit            chk_en;
  logic [DW-1:0] exp_q [$];

  sirv_gnrl_regfifo #(.DW(DW), .DP(DP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .i_vld (i_vld),
    .i_rdy (i_rdy),
    .i_dat (i_dat),
    .o_vld (o_vld),
    .o_rdy (o_rdy),
    .o_dat (o_dat),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic r);
    @(posedge clk);
    #1;
    i_vld = v;
    i_dat = d;
    o_rdy = r;
  endtask

  // Reference model: occupancy from the handshake rules, data order kept in exp_q.
  initial begin
    mcount = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mcount = 0;
        exp_q.delete();
      end else begin
        bit thru;
        bit mpush;
        bit mpop;
        thru = 1'b0;
`ifdef SIRV_GNRL_REGFIFO_BYPASS_EN
        thru = (mcount == 0) && i_vld && o_rdy;
`endif
        mpush = i_vld && (mcount < DP) && !thru;
        mpop  = o_rdy && (mcount > 0);
        if (mpush) exp_q.push_back(i_dat);
        mcount = mcount + int'(mpush) - int'(mpop);
      end
    end
  end

  // Monitor: samples mid-cycle, pops the scoreboard whenever a handshake is pending.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && chk_en) begin
        bit byp;
        byp = 1'b0;
`ifdef SIRV_GNRL_REGFIFO_BYPASS_EN
        byp = (mcount == 0) && i_vld;
`endif
        chk("i_rdy", 32'(i_rdy), 32'(mcount != DP));
        chk("o_vld", 32'(o_vld), 32'((mcount != 0) || byp));
        chk("count", 32'(count), 32'(mcount));
        if (byp) begin
          chk("o_dat_bypass", 32'(o_dat), 32'(i_dat));
        end else if (mcount != 0 && exp_q.size() > 0) begin
          chk("o_dat_order", 32'(o_dat), 32'(exp_q[0]));
          if (o_rdy) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    total  = 0;
    bad    = 0;
    chk_en = 1'b0;
    rst_n  = 1'b1;
    i_vld  = 1'b0;
    i_dat  = '0;
    o_rdy  = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_i_rdy", 32'(i_rdy), 32'd1);
    chk("rst_o_vld", 32'(o_vld), 32'd0);
    chk("rst_o_dat", 32'(o_dat), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    #9 rst_n = 1'b1;
    chk_en = 1'b1;

    // Fill to full with downstream stalled.
    for (int i = 0; i < 4; i++) drive(1'b1, 8'(8'h11 * (i + 1)), 1'b0);
    drive(1'b0, '0, 1'b0);
    @(negedge clk);
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_i_rdy", 32'(i_rdy), 32'd0);
    chk("fill_o_dat", 32'(o_dat), 32'h11);

    // Drain; order checked by the monitor.
    for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b1);
    drive(1'b0, '0, 1'b0);
    @(negedge clk);
    chk("drain_o_vld", 32'(o_vld), 32'd0);
    chk("drain_count", 32'(count), 32'd0);

    // Streaming with both sides always ready.
    for (int i = 0; i < 20; i++) drive(1'b1, 8'(i), 1'b1);
    drive(1'b0, '0, 1'b1);
    drive(1'b0, '0, 1'b0);
    @(negedge clk);
    chk("stream_count", 32'(count), 32'd0);

    // Full with simultaneous pop: push refused.
    for (int i = 0; i < 4; i++) drive(1'b1, 8'(8'hC0 + i), 1'b0);
    drive(1'b1, 8'h55, 1'b1);
    drive(1'b0, '0, 1'b0);
    @(negedge clk);
    chk("fullpop_count", 32'(count), 32'd3);
    chk("fullpop_o_dat", 32'(o_dat), 32'hC1);

    // Mid-operation reset, pulsed between edges.
    drive(1'b0, '0, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_o_vld", 32'(o_vld), 32'd0);
    chk("mrst_count", 32'(count), 32'd0);
    chk("mrst_o_dat", 32'(o_dat), 32'd0);
    #1 rst_n = 1'b1;
    drive(1'b1, 8'hAA, 1'b0);
    drive(1'b0, '0, 1'b0);
    @(negedge clk);
    chk("mrst_first", 32'(o_dat), 32'hAA);
    drive(1'b0, '0, 1'b1);

    // Empty FIFO, beat offered with downstream ready.
    drive(1'b1, 8'h5A, 1'b1);
    @(negedge clk);
`ifdef SIRV_GNRL_REGFIFO_BYPASS_EN
    chk("byp_o_vld", 32'(o_vld), 32'd1);
    chk("byp_o_dat", 32'(o_dat), 32'h5A);
    chk("byp_count", 32'(count), 32'd0);
`else
    chk("nobyp_o_vld", 32'(o_vld), 32'd0);
`endif
    drive(1'b0, '0, 1'b0);
    @(negedge clk);
`ifdef SIRV_GNRL_REGFIFO_BYPASS_EN
    chk("byp_after_count", 32'(count), 32'd0);
`else
    chk("nobyp_next_vld", 32'(o_vld), 32'd1);
    chk("nobyp_next_dat", 32'(o_dat), 32'h5A);
`endif
    drive(1'b0, '0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 6; i++) drive(1'b0, '0, 1'b1);
    drive(1'b0, '0, 1'b0);
    @(negedge clk);
    chk("end_count", 32'(count), 32'd0);
    chk("end_scoreboard", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
